sdp_ram_bank: RTL

Parametrised single-clock simple-dual-port RAM with byte-lane write enables, a read-valid flag, a selectable read-during-write policy and a self-sequencing memory initialisation sweep. It is the buffering primitive for synchronous FIFOs, line buffers and register-file style storage. Unlike the earlier two-clock array, it never writes zeros on idle cycles and holds read data between reads. After reset or a clear request, every word holds a known value before the first access is accepted.

---
 rtl/sdp_ram_bank_if.sv | 30 +++
 rtl/sdp_ram_bank.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sdp_ram_bank_if.sv
// Access bundle for sdp_ram_bank: write/read requests, clear and status.
// The master drives requests and observes read results; the RAM is the slave.
interface sdp_ram_bank_if #(
  parameter int ADDSIZE  = 8,
  parameter int DATASIZE = 8
);
  localparam int BYTES = DATASIZE / 8;

  logic                clr;
  logic                wen;
  logic [ADDSIZE-1:0]  waddr;
  logic [DATASIZE-1:0] wdata;
  logic [BYTES-1:0]    wbe;
  logic                ren;
  logic [ADDSIZE-1:0]  raddr;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                init_busy;
  logic                acc_drop;

  modport master (
    output clr, wen, waddr, wdata, wbe, ren, raddr,
    input  rdata, rvalid, init_busy, acc_drop
  );

  modport slave (
    input  clr, wen, waddr, wdata, wbe, ren, raddr,
    output rdata, rvalid, init_busy, acc_drop
  );
endinterface

// File: rtl/sdp_ram_bank.sv
// Single-clock simple-dual-port RAM with byte lanes and a self-running init sweep.
// Optional macro SDP_RAM_OUTREG_EN adds a second read output register (latency 2).
module sdp_ram_bank #(
  parameter int                    ADDSIZE   = 8,
  parameter int                    DATASIZE  = 8,
  parameter int                    READ_MODE = 0,
  parameter logic [DATASIZE-1:0]   INIT_VAL  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdp_ram_bank_if.slave        bus
);
  localparam int DEPTH = 1 << ADDSIZE;
  localparam int BYTES = DATASIZE / 8;

  typedef enum logic {INIT, READY} state_e;

  state_e              state_q, state_d;
  logic [ADDSIZE-1:0]  cnt_q, cnt_d;
  logic                initBusy;
  logic                accept;
  logic                dropped;
  logic                accDrop_q;
  logic                rvalid_d;
  logic [DATASIZE-1:0] rdWord;
  logic [DATASIZE-1:0] mergedWord;
  logic [DATASIZE-1:0] rdata_q;
  logic                rvalid_q;
  logic [DATASIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
    // clr restarts the sweep from either state
    if (bus.clr) begin
      state_d = INIT;
      cnt_d   = '0;
    end
  end

  always_comb begin
    initBusy = (state_q == INIT);
    accept   = (state_q == READY);
    dropped  = (bus.wen || bus.ren) && !accept;
  end

  // Memory array is deliberately not reset; the sweep gives it known contents.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (bus.wen) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.wbe[b]) mem[bus.waddr][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdWord     = mem[bus.raddr];
    mergedWord = rdWord;
    if (READ_MODE == 1 && bus.wen && bus.waddr == bus.raddr) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.wbe[b]) mergedWord[8*b +: 8] = bus.wdata[8*b +: 8];
      end
    end
`ifdef SDP_RAM_OUTREG_EN
    rvalid_d = bus.ren && accept && !bus.clr;
`else
    rvalid_d = bus.ren && accept;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      accDrop_q <= 1'b0;
    end else begin
      rvalid_q  <= rvalid_d;
      accDrop_q <= dropped;
      if (rvalid_d) rdata_q <= mergedWord;
    end
  end

`ifdef SDP_RAM_OUTREG_EN
  logic [DATASIZE-1:0] rdataOut_q;
  logic                rvalidOut_q;

  // Second stage only reloads on a valid stage-1 result, so rdata still holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdataOut_q  <= '0;
      rvalidOut_q <= 1'b0;
    end else begin
      rvalidOut_q <= rvalid_q && !bus.clr;
      if (rvalid_q) rdataOut_q <= rdata_q;
    end
  end

  assign bus.rdata  = rdataOut_q;
  assign bus.rvalid = rvalidOut_q;
`else
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
`endif

  assign bus.init_busy = initBusy;
  assign bus.acc_drop  = accDrop_q;
endmodule
